// File: rtl/serdes_pkg.sv
// Shared definitions for the serial transmit/receive blocks.
package serdes_pkg;

    // Word width shared with the companion serial-to-parallel receiver.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Widest word the parity helper accepts. Callers zero-extend to this width.
    localparam int unsigned PARITY_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2
    } tx_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts DIV cycles per serial bit and flags the last one.
module bit_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,     // next cycle is the first cycle of a frame
    input  logic en_i,        // current cycle belongs to a frame
    output logic tick_o,      // current cycle is the last of a bit period
    output logic tick_next_o  // next cycle would be the last of a bit period
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Wrap at DIV-1; hold at zero outside a frame so every frame starts aligned.
    always_comb begin
        cnt_d = '0;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o      = en_i && (cnt_q == LastCnt);
    assign tick_next_o = (cnt_d == LastCnt);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and optional even parity.
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DIV       = 1,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             frame_start_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned NBITS   = WIDTH + PARITY_EN;
    localparam int unsigned BitCntW = $clog2(NBITS + 1);
    localparam logic [BitCntW-1:0] LastData = BitCntW'(WIDTH - 1);
    localparam logic [BitCntW-1:0] LastBit  = BitCntW'(NBITS - 1);

    tx_state_e          state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d, shift_adv;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic               parity_q, parity_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               done_q, done_d;
    logic               accept;
    logic               tick, tick_next;
    logic               head_d;

    assign load_ready_o = (state_q == StIdle);
    assign busy_o       = ~load_ready_o;
    assign accept       = load_valid_i && load_ready_o;

    bit_tick_gen #(
        .DIV (DIV)
    ) u_bit_tick_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (accept),
        .en_i        (state_q != StIdle),
        .tick_o      (tick),
        .tick_next_o (tick_next)
    );

    // Shift toward the transmit end so the head is always the next bit to send.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_adv = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_adv = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    // Frame sequencing: load, shift one bit per tick, optional parity bit, back to idle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        unique case (state_q)
            StIdle: begin
                if (load_valid_i) begin
                    shift_d   = din_i;
                    parity_d  = even_parity(PARITY_MAX_WIDTH'(din_i));
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = shift_adv;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastData) begin
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                        end else begin
                            state_d   = StIdle;
                            bit_cnt_d = '0;
                            parity_d  = 1'b0;
                        end
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    parity_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered, so derive them from next-cycle state.
    always_comb begin
        head_d = (MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0];
        sout_d = 1'b0;
        if (state_d == StData) begin
            sout_d = head_d;
        end else if (state_d == StParity) begin
            sout_d = parity_d;
        end
        sout_valid_d  = (state_d != StIdle);
        frame_start_d = accept;
        done_d        = (state_d != StIdle) && (bit_cnt_d == LastBit) && tick_next;
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            parity_q      <= 1'b0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            parity_q      <= parity_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign sout_o        = sout_q;
    assign sout_valid_o  = sout_valid_q;
    assign frame_start_o = frame_start_q;
    assign done_o        = done_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit at a time, with a programmable bit period and an optional even-parity bit. It is the transmit-side counterpart to the team's parallel and serial-capture registers. It sits between a parallel data source and a single-wire serial link, with a framing strobe for the downstream serial-to-parallel receiver.

## Interface

Parameters:

- WIDTH, 4, data word width in bits (≥2)
- DIV, 1, clock cycles per serial bit (≥1)
- MSB_FIRST, 0, 1 = shift din[WIDTH-1] first, 0 = shift din[0] first
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits

Ports (name, direction, width, meaning):

- clk, in, 1, rising-edge clock
- rst, in, 1, reset; synchronous, active-high
- din, in, WIDTH, parallel word to transmit
- load_valid, in, 1, din is valid
- load_ready, out, 1, block can accept a word (high only in IDLE)
- sout, out, 1, serial data bit; 0 when sout_valid = 0
- sout_valid, out, 1, sout carries a frame bit
- frame_start, out, 1, one-cycle pulse on the first cycle of the first bit
- done, out, 1, one-cycle pulse on the final cycle of the last bit (data or parity)
- busy, out, 1, inverse of load_ready

## Operation

- Frame length is NBITS = WIDTH + PARITY_EN.
- The state machine has three states: IDLE, DATA, PARITY.
- **IDLE**
  - load_ready = 1.
  - When load_valid = 1, capture din into the shift register and compute parity = XOR of din. Go to DATA with bit_cnt = 0 and div_cnt = 0.
- **DATA**
  - sout = current head bit of the shift register (MSB or LSB per MSB_FIRST).
  - div_cnt counts 0..DIV-1. On the DIV-1 tick, shift by one and increment bit_cnt.
  - After WIDTH bits, go to PARITY if PARITY_EN = 1, otherwise go to IDLE.
- **PARITY**
  - sout = stored parity for DIV cycles, then go to IDLE.
- **Handshake**
  - The transfer happens only when load_valid && load_ready.
  - load_valid asserted while busy is ignored; the word is neither queued nor dropped silently, because load_ready stays low.
  - din is sampled only on the accept cycle. Changes to din mid-frame have no effect.
- **Reset values** (every cycle that rst = 1, and the cycle after it):
  - state = IDLE
  - sout = 0, sout_valid = 0, frame_start = 0, done = 0, busy = 0, load_ready = 1
  - shift register, counters, and parity all 0
- **Reset mid-frame:** the frame is abandoned. No done pulse. The next cycle is IDLE.
- **rst and load_valid high together:** rst wins. Nothing is accepted.
- **Width rules:**
  - bit_cnt is $clog2(NBITS+1) bits.
  - div_cnt is max(1, $clog2(DIV)) bits.
  - Counters never wrap within a frame.

## Timing

- Accept on cycle T. The first bit is on sout during cycles T+1 .. T+DIV. frame_start = 1 at T+1.
- Bit k occupies cycles T+1+k·DIV .. T+(k+1)·DIV.
- done = 1 at cycle T + NBITS·DIV.
- load_ready = 1 again at T + NBITS·DIV + 1. The earliest next accept is that cycle, so the minimum frame period is NBITS·DIV + 1 cycles.
- All outputs are registered, except load_ready and busy, which decode the registered state.

## Structure

- Shared package serdes_pkg holds:
  - the state typedef (IDLE, DATA, PARITY)
  - the even-parity function
  - constant DEFAULT_WIDTH = 4, reused by the companion serial-to-parallel receiver
- One sub-module, bit_tick_gen, wraps div_cnt. Its inputs are clk, rst and a start/enable. It outputs a one-cycle tick at the end of each DIV-cycle bit period.
- The shifter, FSM and output registers live in piso_serializer.

## Test plan

- **LSB-first, DIV=1** (WIDTH=4, PARITY_EN=0): load 4'b1011 at T=0.
  - sout = 1,1,0,1 at T=1..4.
  - frame_start at T=1, done at T=4, load_ready = 1 at T=5.
- **MSB_FIRST=1:** load 4'b1011.
  - sout = 1,0,1,1 at T=1..4.
- **Parity:** PARITY_EN=1, load 4'b0111.
  - Data bits 1,1,1,0 are followed by parity bit 1 at T=5.
  - done at T=5.
- **DIV=3:** load 4'b0001.
  - sout = 1 for T=1..3, then 0 for T=4..12.
  - done at T=12, load_ready at T=13.
- **Load while busy:** hold load_valid high with 4'b1111, then 4'b0000 from T=1.
  - 4'b1111 is accepted at T=0. Nothing is accepted at T=1..4.
  - 4'b0000 is accepted at T=5 and transmitted at T=6..9.
- **Reset mid-frame:** rst = 1 at T=2.
  - At T=3: sout_valid = 0, sout = 0, load_ready = 1.
  - No done pulse at any cycle. A new load at T=3 starts cleanly with frame_start at T=4.
